// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control encodings and opcode constants for the issue arbiter and its decoder.
// The ALU codes are the contract between the decoder and the ALU.
package alu_ctrl_pkg;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  localparam logic [4:0] ALU_ADD     = 5'b00000;
  localparam logic [4:0] ALU_SUB     = 5'b00001;
  localparam logic [4:0] ALU_SLL     = 5'b00010;
  localparam logic [4:0] ALU_SLT     = 5'b00011;
  localparam logic [4:0] ALU_SLTU    = 5'b00100;
  localparam logic [4:0] ALU_XOR     = 5'b00101;
  localparam logic [4:0] ALU_SRL     = 5'b00110;
  localparam logic [4:0] ALU_SRA     = 5'b00111;
  localparam logic [4:0] ALU_OR      = 5'b01000;
  localparam logic [4:0] ALU_AND     = 5'b01001;
  localparam logic [4:0] ALU_ADDI    = 5'b01010;
  localparam logic [4:0] ALU_SLTI    = 5'b01011;
  localparam logic [4:0] ALU_SLTIU   = 5'b01100;
  localparam logic [4:0] ALU_XORI    = 5'b01101;
  localparam logic [4:0] ALU_ORI     = 5'b01110;
  localparam logic [4:0] ALU_ANDI    = 5'b01111;
  localparam logic [4:0] ALU_SLLI    = 5'b10001;
  localparam logic [4:0] ALU_SRLI    = 5'b10010;
  localparam logic [4:0] ALU_SRAI    = 5'b10011;
  localparam logic [4:0] ALU_ILLEGAL = 5'b11111;

  // Immediate-form codes take the sign-extended 12-bit immediate from b[11:0].
  function automatic logic uses_imm(input logic [4:0] ctl);
    return ctl inside {ALU_ADDI, ALU_SLTI, ALU_SLTIU, ALU_XORI, ALU_ORI,
                       ALU_ANDI, ALU_SLLI, ALU_SRLI, ALU_SRAI};
  endfunction

endpackage

// File: rtl/alu_core.sv
// Single-cycle 32-bit integer ALU driven by the 5-bit control code.
// Immediate forms sign-extend b[11:0]; the illegal code yields zero.
module alu_core
  import alu_ctrl_pkg::*;
(
  input  logic [4:0]  alu_ctl_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] result_o
);

  logic [31:0] imm;
  logic [31:0] opb;
  logic [4:0]  shamt;

  assign imm   = {{20{b_i[11]}}, b_i[11:0]};
  assign opb   = uses_imm(alu_ctl_i) ? imm : b_i;
  assign shamt = opb[4:0];

  always_comb begin
    result_o = '0;
    case (alu_ctl_i)
      ALU_ADD, ALU_ADDI:   result_o = a_i + opb;
      ALU_SUB:             result_o = a_i - opb;
      ALU_SLL, ALU_SLLI:   result_o = a_i << shamt;
      ALU_SLT, ALU_SLTI:   result_o = {31'b0, $signed(a_i) < $signed(opb)};
      ALU_SLTU, ALU_SLTIU: result_o = {31'b0, a_i < opb};
      ALU_XOR, ALU_XORI:   result_o = a_i ^ opb;
      ALU_SRL, ALU_SRLI:   result_o = a_i >> shamt;
      ALU_SRA, ALU_SRAI:   result_o = $unsigned($signed(a_i) >>> shamt);
      ALU_OR, ALU_ORI:     result_o = a_i | opb;
      ALU_AND, ALU_ANDI:   result_o = a_i & opb;
      default:             result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_op_decode.sv
// Combinational RV32I opcode/funct3/funct7[5] to ALU control decode.
// Anything that is not a legal OP or OP-IMM encoding maps to ALU_ILLEGAL.
module alu_op_decode
  import alu_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output logic [4:0] alu_ctl_o,
  output logic       illegal_o
);

  always_comb begin
    alu_ctl_o = ALU_ILLEGAL;
    if (opcode_i == OP_R) begin
      case (funct3_i)
        3'b000:  alu_ctl_o = funct7b5_i ? ALU_SUB : ALU_ADD;
        3'b001:  alu_ctl_o = funct7b5_i ? ALU_ILLEGAL : ALU_SLL;
        3'b010:  alu_ctl_o = funct7b5_i ? ALU_ILLEGAL : ALU_SLT;
        3'b011:  alu_ctl_o = funct7b5_i ? ALU_ILLEGAL : ALU_SLTU;
        3'b100:  alu_ctl_o = funct7b5_i ? ALU_ILLEGAL : ALU_XOR;
        3'b101:  alu_ctl_o = funct7b5_i ? ALU_SRA : ALU_SRL;
        3'b110:  alu_ctl_o = funct7b5_i ? ALU_ILLEGAL : ALU_OR;
        default: alu_ctl_o = funct7b5_i ? ALU_ILLEGAL : ALU_AND;
      endcase
    end else if (opcode_i == OP_I) begin
      // Outside the shifts, inst[30] is just an immediate bit and is ignored.
      case (funct3_i)
        3'b000:  alu_ctl_o = ALU_ADDI;
        3'b001:  alu_ctl_o = funct7b5_i ? ALU_ILLEGAL : ALU_SLLI;
        3'b010:  alu_ctl_o = ALU_SLTI;
        3'b011:  alu_ctl_o = ALU_SLTIU;
        3'b100:  alu_ctl_o = ALU_XORI;
        3'b101:  alu_ctl_o = funct7b5_i ? ALU_SRAI : ALU_SRLI;
        3'b110:  alu_ctl_o = ALU_ORI;
        default: alu_ctl_o = ALU_ANDI;
      endcase
    end
    illegal_o = (alu_ctl_o == ALU_ILLEGAL);
  end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Shares one ALU between the execute stage (req0) and the branch/address unit (req1),
// with round-robin (or fixed) arbitration and a one-entry registered result slot.
module alu_issue_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int TAG_W      = 4,
  parameter int PRIO_FIXED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [6:0]       req0_opcode_i,
  input  logic [2:0]       req0_funct3_i,
  input  logic             req0_funct7b5_i,
  input  logic [31:0]      req0_a_i,
  input  logic [31:0]      req0_b_i,
  input  logic [TAG_W-1:0] req0_tag_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [6:0]       req1_opcode_i,
  input  logic [2:0]       req1_funct3_i,
  input  logic             req1_funct7b5_i,
  input  logic [31:0]      req1_a_i,
  input  logic [31:0]      req1_b_i,
  input  logic [TAG_W-1:0] req1_tag_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_id_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic [31:0]      rsp_result_o,
  output logic             rsp_illegal_o,
  output logic             rr_last_o
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high.
  // Producers hold valid and payload until ready; ready may depend combinationally on
  // rsp_ready_i, so a full slot drains and reloads in the same cycle.

  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic [31:0]      rsp_result_q, rsp_result_d;
  logic             rsp_illegal_q, rsp_illegal_d;
  logic             rr_last_q, rr_last_d;

  logic             slot_free;
  logic             any_valid;
  logic             grant_id;
  logic             accept;

  logic [6:0]       sel_opcode;
  logic [2:0]       sel_funct3;
  logic             sel_funct7b5;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;
  logic [TAG_W-1:0] sel_tag;
  logic [4:0]       alu_ctl;
  logic             dec_illegal;
  logic [31:0]      alu_result;

  assign slot_free = !rsp_valid_q || rsp_ready_i;
  assign any_valid = req0_valid_i || req1_valid_i;
  assign accept    = slot_free && any_valid;

  // rr_last names the requester that won last; on contention the other one wins.
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      grant_id = (PRIO_FIXED != 0) ? 1'b0 : !rr_last_q;
    end else if (req1_valid_i) begin
      grant_id = 1'b1;
    end
  end

  assign req0_ready_o = slot_free && req0_valid_i && (grant_id == 1'b0);
  assign req1_ready_o = slot_free && req1_valid_i && (grant_id == 1'b1);

  always_comb begin
    sel_opcode   = req0_opcode_i;
    sel_funct3   = req0_funct3_i;
    sel_funct7b5 = req0_funct7b5_i;
    sel_a        = req0_a_i;
    sel_b        = req0_b_i;
    sel_tag      = req0_tag_i;
    if (grant_id) begin
      sel_opcode   = req1_opcode_i;
      sel_funct3   = req1_funct3_i;
      sel_funct7b5 = req1_funct7b5_i;
      sel_a        = req1_a_i;
      sel_b        = req1_b_i;
      sel_tag      = req1_tag_i;
    end
  end

  alu_op_decode u_decode (
    .opcode_i   (sel_opcode),
    .funct3_i   (sel_funct3),
    .funct7b5_i (sel_funct7b5),
    .alu_ctl_o  (alu_ctl),
    .illegal_o  (dec_illegal)
  );

  alu_core u_alu (
    .alu_ctl_i (alu_ctl),
    .a_i       (sel_a),
    .b_i       (sel_b),
    .result_o  (alu_result)
  );

  always_comb begin
    rsp_valid_d   = rsp_valid_q;
    rsp_id_d      = rsp_id_q;
    rsp_tag_d     = rsp_tag_q;
    rsp_result_d  = rsp_result_q;
    rsp_illegal_d = rsp_illegal_q;
    rr_last_d     = rr_last_q;
    if (accept) begin
      rsp_valid_d   = 1'b1;
      rsp_id_d      = grant_id;
      rsp_tag_d     = sel_tag;
      rsp_result_d  = alu_result;
      rsp_illegal_d = dec_illegal;
      rr_last_d     = grant_id;
    end else if (rsp_ready_i) begin
      // Drain without refill: payload fields keep their last value.
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_tag_q     <= '0;
      rsp_result_q  <= '0;
      rsp_illegal_q <= 1'b0;
      rr_last_q     <= 1'b1;
    end else begin
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_tag_q     <= rsp_tag_d;
      rsp_result_q  <= rsp_result_d;
      rsp_illegal_q <= rsp_illegal_d;
      rr_last_q     <= rr_last_d;
    end
  end

  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_id_o      = rsp_id_q;
  assign rsp_tag_o     = rsp_tag_q;
  assign rsp_result_o  = rsp_result_q;
  assign rsp_illegal_o = rsp_illegal_q;
  assign rr_last_o     = rr_last_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: instruction-level result model, per-cycle scoreboard
// compare, and directed scenarios with literal expectations.
module tb_alu_issue_arbiter;

  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] OPC_LD = 7'b0000011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v0 = 0, v1 = 0;
  logic        r0, r1;
  logic [6:0]  op0 = '0, op1 = '0;
  logic [2:0]  f30 = '0, f31 = '0;
  logic        f70 = 0, f71 = 0;
  logic [31:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
  logic [3:0]  t0 = '0, t1 = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_illegal, rr_last;
  logic [3:0]  rsp_tag;
  logic [31:0] rsp_result;

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  // Scoreboard entry: {illegal, id, tag, result}
  logic [37:0] exp_q[$];
  logic        m_rr_last = 1'b1;

  alu_issue_arbiter #(.TAG_W(4), .PRIO_FIXED(0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid_i(v0), .req0_ready_o(r0), .req0_opcode_i(op0), .req0_funct3_i(f30),
    .req0_funct7b5_i(f70), .req0_a_i(a0), .req0_b_i(b0), .req0_tag_i(t0),
    .req1_valid_i(v1), .req1_ready_o(r1), .req1_opcode_i(op1), .req1_funct3_i(f31),
    .req1_funct7b5_i(f71), .req1_a_i(a1), .req1_b_i(b1), .req1_tag_i(t1),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
    .rsp_tag_o(rsp_tag), .rsp_result_o(rsp_result), .rsp_illegal_o(rsp_illegal),
    .rr_last_o(rr_last)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model ----------------
  // Instruction semantics straight from RV32I; returns {illegal, result}.
  function automatic logic [32:0] model_alu(input logic [6:0] op, input logic [2:0] f3,
                                            input logic f7, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] imm;
    logic [31:0] y;
    imm = {{20{b[11]}}, b[11:0]};
    if (op == OPC_R) begin
      if (f7 && !(f3 == 3'd0 || f3 == 3'd5)) return {1'b1, 32'd0};
      case (f3)
        3'd0: y = f7 ? a - b : a + b;
        3'd1: y = a << b[4:0];
        3'd2: y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: y = (a < b) ? 32'd1 : 32'd0;
        3'd4: y = a ^ b;
        3'd5: y = f7 ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
        3'd6: y = a | b;
        default: y = a & b;
      endcase
      return {1'b0, y};
    end
    if (op == OPC_I) begin
      if (f3 == 3'd1 && f7) return {1'b1, 32'd0};
      case (f3)
        3'd0: y = a + imm;
        3'd1: y = a << imm[4:0];
        3'd2: y = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
        3'd3: y = (a < imm) ? 32'd1 : 32'd0;
        3'd4: y = a ^ imm;
        3'd5: y = f7 ? $unsigned($signed(a) >>> imm[4:0]) : a >> imm[4:0];
        3'd6: y = a | imm;
        default: y = a & imm;
      endcase
      return {1'b0, y};
    end
    return {1'b1, 32'd0};
  endfunction

  // Winner under contention is whoever did not win last time.
  function automatic logic model_grant(input logic va, input logic vb, input logic last);
    if (va && vb) return !last;
    return vb;
  endfunction

  always @(posedge clk or posedge rst) begin : model_upd
    logic [32:0] r;
    logic        g, full, free;
    if (rst) begin
      exp_q.delete();
      m_rr_last = 1'b1;
    end else begin
      full = (exp_q.size() != 0);
      free = !full || rsp_ready;
      g    = model_grant(v0, v1, m_rr_last);
      if (full && rsp_ready) void'(exp_q.pop_front());
      if (free && (v0 || v1)) begin
        r = g ? model_alu(op1, f31, f71, a1, b1) : model_alu(op0, f30, f70, a0, b0);
        exp_q.push_back({r[32], g, g ? t1 : t0, r[31:0]});
        m_rr_last = g;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [37:0] act, input logic [37:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : compare
    logic full, free, g;
    if (!rst && chk_en) begin
      full = (exp_q.size() != 0);
      free = !full || rsp_ready;
      g    = model_grant(v0, v1, m_rr_last);
      chk("rsp_valid", rsp_valid, full);
      if (full) chk("rsp_slot", {rsp_illegal, rsp_id, rsp_tag, rsp_result}, exp_q[0]);
      chk("req0_ready", r0, free && v0 && !g);
      chk("req1_ready", r1, free && v1 && g);
      chk("rr_last", rr_last, m_rr_last);
    end
  end

  // ---------------- drivers ----------------
  task automatic do_reset();
    rst = 1'b1;
    v0 = 0; v1 = 0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic set_req(input int n, input logic [6:0] op, input logic [2:0] f3,
                         input logic f7, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag);
    if (n == 0) begin
      op0 = op; f30 = f3; f70 = f7; a0 = a; b0 = b; t0 = tag; v0 = 1'b1;
    end else begin
      op1 = op; f31 = f3; f71 = f7; a1 = a; b1 = b; t1 = tag; v1 = 1'b1;
    end
  endtask

  // One lone request; returns at the negedge where its result should sit in the slot.
  task automatic single(input int n, input logic [6:0] op, input logic [2:0] f3,
                        input logic f7, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag);
    @(posedge clk); #1;
    v0 = 0; v1 = 0;
    set_req(n, op, f3, f7, a, b, tag);
    @(posedge clk); #1;
    v0 = 0; v1 = 0;
    @(negedge clk);
    chk("single_valid", rsp_valid, 1'b1);
    chk("single_id", rsp_id, n[0]);
    chk("single_tag", rsp_tag, tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset();
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_outputs", {rsp_valid, rsp_illegal, rsp_id, rsp_tag, rsp_result}, 38'd0);
    chk("reset_rr_last", rr_last, 1'b1);

    // 1: basic add on req0
    single(0, OPC_R, 3'b000, 1'b0, 32'd5, 32'd7, 4'd3);
    chk("t1_result", rsp_result, 32'd12);
    chk("t1_illegal", rsp_illegal, 1'b0);

    // 2: both valid every cycle from reset -> grants 0,1,0,1,...
    do_reset();
    set_req(0, OPC_R, 3'b000, 1'b0, 32'd1, 32'd2, 4'd1);
    set_req(1, OPC_R, 3'b100, 1'b0, 32'hF0F0, 32'h0FF0, 4'd2);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t2_ready0", r0, (k % 2) == 0);
      chk("t2_ready1", r1, (k % 2) == 1);
      if (k > 0) begin
        chk("t2_valid", rsp_valid, 1'b1);
        chk("t2_id", rsp_id, ((k - 1) % 2) == 1);
        chk("t2_result", rsp_result, ((k - 1) % 2) == 1 ? 32'hFF00 : 32'd3);
      end
    end

    // 3: arithmetic vs logical right shift immediate on req1
    single(1, OPC_I, 3'b101, 1'b1, 32'h8000_0000, 32'h0000_0404, 4'd5);
    chk("t3_srai", rsp_result, 32'hF800_0000);
    single(1, OPC_I, 3'b101, 1'b0, 32'h8000_0000, 32'h0000_0004, 4'd6);
    chk("t3_srli", rsp_result, 32'h0800_0000);

    // 4: stall with both valid, then release
    single(0, OPC_R, 3'b000, 1'b0, 32'd10, 32'd20, 4'd7);
    rsp_ready = 1'b0;
    set_req(0, OPC_R, 3'b000, 1'b1, 32'd50, 32'd8, 4'd8);
    set_req(1, OPC_R, 3'b110, 1'b0, 32'h0F0, 32'h00F, 4'd9);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_stall_ready", {r0, r1}, 2'b00);
      chk("t4_stall_slot", {rsp_valid, rsp_tag, rsp_result}, {1'b1, 4'd7, 32'd30});
    end
    rsp_ready = 1'b1;
    #1 chk("t4_release_ready", {r0, r1}, 2'b01);
    @(posedge clk); #1;
    v0 = 0; v1 = 0;
    @(negedge clk);
    chk("t4_after", {rsp_valid, rsp_id, rsp_tag, rsp_result}, {1'b1, 1'b1, 4'd9, 32'h0FF});

    // 5: illegal encodings and signed/unsigned immediates
    single(0, OPC_LD, 3'b010, 1'b0, 32'd123, 32'd4, 4'd1);
    chk("t5_load", {rsp_illegal, rsp_result}, {1'b1, 32'd0});
    single(0, OPC_I, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'h0000_0FFF, 4'd2);
    chk("t5_slti", {rsp_illegal, rsp_result}, {1'b0, 32'd0});
    single(0, OPC_I, 3'b011, 1'b0, 32'd5, 32'h0000_0FFF, 4'd3);
    chk("t5_sltiu", rsp_result, 32'd1);
    single(0, OPC_R, 3'b000, 1'b1, 32'd5, 32'd7, 4'd4);
    chk("t5_sub", rsp_result, 32'hFFFF_FFFE);
    single(0, OPC_R, 3'b001, 1'b1, 32'd5, 32'd1, 4'd5);
    chk("t5_sll_f7", {rsp_illegal, rsp_result}, {1'b1, 32'd0});
    single(0, OPC_I, 3'b001, 1'b1, 32'd1, 32'h0000_0401, 4'd6);
    chk("t5_slli_f7", rsp_illegal, 1'b1);
    single(0, OPC_I, 3'b001, 1'b0, 32'd1, 32'h0000_001F, 4'd7);
    chk("t5_slli", rsp_result, 32'h8000_0000);

    // 6: asynchronous reset while the slot is full
    single(0, OPC_R, 3'b111, 1'b0, 32'hFF00, 32'h0FF0, 4'd8);
    #2 rst = 1'b1;
    #1 chk("t6_async_clear", rsp_valid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    set_req(0, OPC_R, 3'b000, 1'b0, 32'd2, 32'd2, 4'd10);
    set_req(1, OPC_R, 3'b000, 1'b0, 32'd3, 32'd3, 4'd11);
    @(negedge clk);
    chk("t6_first_grant", {r0, r1}, 2'b10);
    @(posedge clk); #1;
    v0 = 0; v1 = 0;
    @(negedge clk);
    chk("t6_first_rsp", {rsp_id, rsp_result}, {1'b0, 32'd4});

    repeat (2) @(negedge clk);
    chk("final_drained", rsp_valid, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
